phase_timer: RTL and testbench

- Per-phase duration timer that closes the loop with the traffic light FSM.
- Consumes the FSM's 4-bit `state` and produces the `expired` pulse the FSM uses to advance.
- Each phase class has its own duration in seconds: primary green, extended green, yellow, all-red.
- A 1-second prescaler makes the durations wall-clock. `time_left` is exported for a countdown display.

---
 rtl/phase_timer.sv | 105 ++++++++++
 tb/tb_phase_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// Per-phase duration timer: loads the duration for the current FSM state, counts it
// down in 1-second ticks and pulses `expired` so the FSM can advance.
module phase_timer #(
   parameter int CLK_PER_SEC = 50000000,
   parameter int T_PRIMARY   = 10,
   parameter int T_EXTENDED  = 20,
   parameter int T_YELLOW    = 3,
   parameter int T_ALL_RED   = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       state,
   input  logic             enable,
   output logic             expired,
   output logic [CNT_W-1:0] time_left,
   output logic             tick_1s
);

   localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);

   typedef enum logic [1:0] {LOAD, COUNT, HOLD} phase_t;

   phase_t           phase, phase_n;
   logic [PRE_W-1:0] pre, pre_n;
   logic [CNT_W-1:0] time_left_n;
   logic             expired_n;
   logic             tick_n;
   logic [3:0]       state_q;

   // A zero-second duration would never expire, so it is stretched to one second.
   function automatic logic [CNT_W-1:0] at_least_one(input int t);
      return (t < 1) ? CNT_W'(1) : CNT_W'(t);
   endfunction

   function automatic logic [CNT_W-1:0] dur(input logic [3:0] s);
      case (s)
         4'd1, 4'd4, 4'd7, 4'd10: return at_least_one(T_PRIMARY);
         4'd2, 4'd5, 4'd8, 4'd11: return at_least_one(T_EXTENDED);
         4'd3, 4'd6, 4'd9, 4'd12: return at_least_one(T_YELLOW);
         default:                 return at_least_one(T_ALL_RED);
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase     <= LOAD;
         pre       <= '0;
         time_left <= '0;
         expired   <= 1'b0;
         tick_1s   <= 1'b0;
         state_q   <= 4'd0;
      end else begin
         phase     <= phase_n;
         pre       <= pre_n;
         time_left <= time_left_n;
         expired   <= expired_n;
         tick_1s   <= tick_n;
         state_q   <= state;
      end
   end

   always_comb begin
      phase_n     = phase;
      pre_n       = pre;
      time_left_n = time_left;
      expired_n   = 1'b0;
      tick_n      = 1'b0;
      case (phase)
         LOAD: begin
            time_left_n = dur(state);
            pre_n       = '0;
            phase_n     = COUNT;
         end
         COUNT: begin
            // A state change (e.g. FSM reset) aborts the count, even on a tick edge.
            if (state != state_q) begin
               phase_n = LOAD;
            end else if (enable) begin
               if (pre == PRE_LAST) begin
                  pre_n  = '0;
                  tick_n = 1'b1;
                  if (time_left <= CNT_W'(1)) begin
                     time_left_n = '0;
                     expired_n   = 1'b1;
                     phase_n     = HOLD;
                  end else begin
                     time_left_n = time_left - CNT_W'(1);
                  end
               end else begin
                  pre_n = pre + PRE_W'(1);
               end
            end
         end
         HOLD: begin
            phase_n = LOAD;
         end
         default: begin
            phase_n = LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with a 4-cycle second and short phase durations.
module tb_phase_timer;

   logic       clk;
   logic       rst;
   logic [3:0] state;
   logic [3:0] state_y;
   logic       enable;
   logic       expired;
   logic [7:0] time_left;
   logic       tick_1s;
   logic       y_expired;
   logic [7:0] y_time_left;
   logic       y_tick_1s;

   int total = 0;
   int bad   = 0;
   int n;
   int ticks;

   phase_timer #(
      .CLK_PER_SEC(4), .T_PRIMARY(3), .T_EXTENDED(5), .T_YELLOW(2), .T_ALL_RED(1), .CNT_W(8)
   ) u_dut (
      .clk(clk), .rst(rst), .state(state), .enable(enable),
      .expired(expired), .time_left(time_left), .tick_1s(tick_1s)
   );

   phase_timer #(
      .CLK_PER_SEC(4), .T_PRIMARY(3), .T_EXTENDED(5), .T_YELLOW(0), .T_ALL_RED(1), .CNT_W(8)
   ) u_y0 (
      .clk(clk), .rst(rst), .state(state_y), .enable(enable),
      .expired(y_expired), .time_left(y_time_left), .tick_1s(y_tick_1s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count edges until the selected instance pulses expired, bounded by max.
   task automatic wait_exp(input bit sel, input int max, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (((sel ? y_expired : expired) == 1'b0) && (cnt < max));
   endtask

   initial begin
      rst = 1'b1; state = 4'd0; state_y = 4'd3; enable = 1'b1;
      step(); step();
      check("reset_expired", expired, 0);
      check("reset_time_left", time_left, 0);
      check("reset_tick", tick_1s, 0);

      // Reset release with state 0: LOAD edge, then expiry 4 edges later.
      rst = 1'b0;
      step();
      check("load_time_left", time_left, 1);
      wait_exp(1'b0, 20, n);
      check("first_expiry_latency", n, 4);
      check("expired_time_left", time_left, 0);
      check("expired_tick", tick_1s, 1);
      step();
      check("pulse_width", expired, 0);
      wait_exp(1'b0, 20, n);
      check("all_red_period", n, 5);

      // Bench acts as the FSM: 0 -> 1 -> 3 -> 0.
      state = 4'd1;
      step(); step();
      check("s1_tl_3", time_left, 3);
      repeat (4) step();
      check("s1_tl_2", time_left, 2);
      repeat (4) step();
      check("s1_tl_1", time_left, 1);
      repeat (4) step();
      check("s1_expired", expired, 1);
      check("s1_tl_0", time_left, 0);
      state = 4'd3;
      wait_exp(1'b0, 40, n);
      check("s3_period", n, 10);
      state = 4'd0;
      wait_exp(1'b0, 40, n);
      check("s0_period", n, 6);

      // Freeze for 10 cycles in the middle of state 1.
      state = 4'd1;
      step(); step();
      repeat (5) step();
      check("gap_tl_before", time_left, 2);
      check("gap_pre_before", u_dut.pre, 1);
      enable = 1'b0;
      ticks = 0;
      repeat (10) begin
         step();
         ticks += int'(tick_1s);
      end
      check("gap_ticks", ticks, 0);
      check("gap_tl_after", time_left, 2);
      check("gap_pre_after", u_dut.pre, 1);
      enable = 1'b1;
      wait_exp(1'b0, 40, n);
      check("gap_remaining", n, 7);

      // Force 2 -> 0 with 4 seconds left: abort, reload, no expiry.
      state = 4'd2;
      step(); step();
      check("s2_load", time_left, 5);
      repeat (4) step();
      check("s2_tl_4", time_left, 4);
      state = 4'd0;
      step();
      check("abort_no_expired", expired, 0);
      step();
      check("abort_no_expired_load", expired, 0);
      check("abort_reload", time_left, 1);

      // Move to yellow (abort + reload) then reset mid-count with 2 left.
      state = 4'd3;
      step(); step();
      check("yellow_load", time_left, 2);
      step();
      rst = 1'b1;
      #1;
      check("async_rst_tl", time_left, 0);
      check("async_rst_expired", expired, 0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_reload", time_left, 2);

      // Undefined state 13 uses the all-red duration.
      state = 4'd13;
      step(); step();
      check("s13_load", time_left, 1);
      wait_exp(1'b0, 20, n);
      check("s13_latency", n, 4);

      // Zero yellow duration runs as one second.
      wait_exp(1'b1, 40, n);
      check("y0_seen", y_expired, 1);
      step(); step();
      check("y0_load", y_time_left, 1);
      wait_exp(1'b1, 40, n);
      check("y0_latency", n, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
